// File: rtl/spi_pkg.sv
// Shared definitions for the SPI flash-side device port.
// Lane-mode encodings plus helpers that derive per-byte edge count and
// the set of IO lanes a mode drives.
package spi_pkg;

  localparam logic [1:0] LANE_SINGLE = 2'd0;
  localparam logic [1:0] LANE_DUAL   = 2'd1;
  localparam logic [1:0] LANE_QUAD   = 2'd2;

  // Rising spi_clk edges needed to move one byte in the given lane mode.
  // The reserved encoding behaves as single.
  function automatic logic [3:0] edges_per_byte(input logic [1:0] mode);
    case (mode)
      LANE_DUAL: return 4'd4;
      LANE_QUAD: return 4'd2;
      default:   return 4'd8;
    endcase
  endfunction

  // IO lanes driven by the device when transmitting in the given mode.
  function automatic logic [3:0] lane_mask(input logic [1:0] mode);
    case (mode)
      LANE_DUAL: return 4'b0011;
      LANE_QUAD: return 4'b1111;
      default:   return 4'b0010;
    endcase
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain.
// Every pin passes through a SYNC_STAGES-deep flop chain. spi_clk edges are
// detected on the last two stages of its chain; cs_n and the IO lanes are
// taken from their final stage, so IO data is at least as old as the edge
// it is sampled with (data is stable for half an SPI period around it).
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   spi_clk       SPI clock pin (async)
//   spi_cs_n      chip select pin, active-low (async)
//   spi_io_in     IO[3:0] pin inputs (async)
//   clk_rise      1-clk pulse on a synchronised rising spi_clk edge
//   clk_fall      1-clk pulse on a synchronised falling spi_clk edge
//   cs_active     synchronised chip select, active-high
//   io_sync       synchronised IO[3:0]
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic [3:0] spi_io_in,
  output logic       clk_rise,
  output logic       clk_fall,
  output logic       cs_active,
  output logic [3:0] io_sync
);

  logic [SYNC_STAGES-1:0]      clk_s;
  logic [SYNC_STAGES-1:0]      cs_s;
  logic [SYNC_STAGES-1:0][3:0] io_s;

  // Stage 0 is the pin-side flop; the chains reset to the idle pin levels
  // (clock low, chip deselected) so no edge is seen coming out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s <= '0;
      cs_s  <= '1;
      io_s  <= '0;
    end else begin
      clk_s <= {clk_s[SYNC_STAGES-2:0], spi_clk};
      cs_s  <= {cs_s[SYNC_STAGES-2:0], spi_cs_n};
      io_s  <= {io_s[SYNC_STAGES-2:0], spi_io_in};
    end
  end

  assign clk_rise  = !clk_s[SYNC_STAGES-1] &&  clk_s[SYNC_STAGES-2];
  assign clk_fall  =  clk_s[SYNC_STAGES-1] && !clk_s[SYNC_STAGES-2];
  assign cs_active = !cs_s[SYNC_STAGES-1];
  assign io_sync   = io_s[SYNC_STAGES-1];

endmodule

// File: rtl/spi_device_multi.sv
// SPI flash-side device port (mode 0), single/dual/quad lanes, fully in clk.
// Receives bytes MSB first on rising spi_clk, transmits on falling spi_clk
// from a one-deep holding register, counts bytes, flags TX underrun and
// reports an idle-clock timeout to the command FSM.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   spi_clk, spi_cs_n          SPI pins (async)
//   spi_io_in/out/oe [3:0]     IO lane inputs, output values, output enables
//   lane_mode [1:0]            0 single, 1 dual, 2 quad, 3 single; per byte
//   tx_en                      device drives during the byte; per byte
//   rx_strobe, rx_cmd          received-byte pulse, first-byte-of-transaction pulse
//   rx_data [7:0]              last received byte
//   rx_count [COUNT_BITS-1:0]  bytes completed this transaction (saturating)
//   tx_data [7:0], tx_valid    next byte to transmit
//   tx_ready                   holding register empty
//   tx_underrun                byte boundary reached with holding register empty
//   timeout                    CS active and no falling spi_clk for 2**TIMEOUT_BITS-1 clk
//
// TX handshake: a byte transfers on any clk where tx_valid && tx_ready;
// tx_ready falls on the next clk and stays low until a byte boundary moves
// the held byte into the shift register. A boundary on the same clk as a
// transfer uses the holding register's previous contents (empty -> underrun)
// and the new byte stays held. While deselected, the holding register is
// kept empty, so bytes offered then are discarded.
module spi_device_multi
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter int         TIMEOUT_BITS = 4,
  parameter int         COUNT_BITS   = 16,
  parameter logic [7:0] FILL_BYTE    = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  spi_cs_n,
  input  logic [3:0]            spi_io_in,
  output logic [3:0]            spi_io_out,
  output logic [3:0]            spi_io_oe,
  input  logic [1:0]            lane_mode,
  input  logic                  tx_en,
  output logic                  rx_strobe,
  output logic                  rx_cmd,
  output logic [7:0]            rx_data,
  output logic [COUNT_BITS-1:0] rx_count,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic                  timeout
);

  logic       clk_rise;
  logic       clk_fall;
  logic       cs_active;
  logic [3:0] io_sync;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk      (clk),
    .reset    (reset),
    .spi_clk  (spi_clk),
    .spi_cs_n (spi_cs_n),
    .spi_io_in(spi_io_in),
    .clk_rise (clk_rise),
    .clk_fall (clk_fall),
    .cs_active(cs_active),
    .io_sync  (io_sync)
  );

  logic [2:0]              edge_cnt;    // rising edges taken in the current byte
  logic [1:0]              mode_q;      // lane mode latched for the current byte
  logic                    tx_en_q;     // tx_en latched for the current byte
  logic                    first_byte;  // no byte completed yet in this transaction
  logic [7:0]              rx_sr;
  logic [7:0]              tx_sr;
  logic [7:0]              hold_q;
  logic                    hold_full;
  logic [TIMEOUT_BITS-1:0] tmo_cnt;

  logic [1:0] lane_norm;
  logic [1:0] mode_eff;
  logic [7:0] rx_next;
  logic       last_edge;

  // On the first edge of a byte the live lane_mode applies, so the bits
  // sampled on that edge already use the new width.
  assign lane_norm = (lane_mode == 2'd3) ? LANE_SINGLE : lane_mode;
  assign mode_eff  = (edge_cnt == 3'd0) ? lane_norm : mode_q;
  assign last_edge = (({1'b0, edge_cnt} + 4'd1) == edges_per_byte(mode_eff));

  always_comb begin
    rx_next = {rx_sr[6:0], io_sync[0]};
    case (mode_eff)
      LANE_DUAL: rx_next = {rx_sr[5:0], io_sync[1:0]};
      LANE_QUAD: rx_next = {rx_sr[3:0], io_sync};
      default:   rx_next = {rx_sr[6:0], io_sync[0]};
    endcase
  end

  // Deselect is handled exactly like reset: any partial byte is dropped.
  always_ff @(posedge clk) begin
    if (reset || !cs_active) begin
      edge_cnt    <= '0;
      mode_q      <= LANE_SINGLE;
      tx_en_q     <= 1'b0;
      first_byte  <= 1'b1;
      rx_sr       <= 8'hFF;
      tx_sr       <= 8'hFF;
      hold_q      <= '0;
      hold_full   <= 1'b0;
      tmo_cnt     <= '1;
      rx_strobe   <= 1'b0;
      rx_cmd      <= 1'b0;
      rx_data     <= '0;
      rx_count    <= '0;
      tx_underrun <= 1'b0;
    end else begin
      rx_strobe   <= 1'b0;
      rx_cmd      <= 1'b0;
      tx_underrun <= 1'b0;

      if (clk_fall) begin
        tmo_cnt <= '1;
      end else if (tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end

      if (clk_rise) begin
        if (edge_cnt == 3'd0) begin
          mode_q  <= lane_norm;
          tx_en_q <= tx_en;
        end
        rx_sr <= rx_next;
        if (last_edge) begin
          edge_cnt   <= '0;
          rx_data    <= rx_next;
          rx_strobe  <= 1'b1;
          rx_cmd     <= first_byte;
          first_byte <= 1'b0;
          if (rx_count != '1) begin
            rx_count <= rx_count + 1'b1;
          end
        end else begin
          edge_cnt <= edge_cnt + 3'd1;
        end
      end

      if (clk_fall) begin
        if (edge_cnt == 3'd0) begin
          // Byte boundary. Before the first byte completes the host has had
          // no chance to supply data, so fill silently.
          if (first_byte) begin
            tx_sr <= FILL_BYTE;
          end else if (hold_full) begin
            tx_sr     <= hold_q;
            hold_full <= 1'b0;
          end else begin
            tx_sr       <= FILL_BYTE;
            tx_underrun <= 1'b1;
          end
        end else begin
          case (mode_q)
            LANE_DUAL: tx_sr <= {tx_sr[5:0], 2'b11};
            LANE_QUAD: tx_sr <= {tx_sr[3:0], 4'hF};
            default:   tx_sr <= {tx_sr[6:0], 1'b1};
          endcase
        end
      end

      // Only possible when empty, so it never collides with the consume above.
      if (tx_valid && !hold_full) begin
        hold_q    <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  always_comb begin
    spi_io_out = '0;
    spi_io_oe  = '0;
    if (cs_active) begin
      case (mode_q)
        LANE_DUAL: spi_io_out[1:0] = tx_sr[7:6];
        LANE_QUAD: spi_io_out      = tx_sr[7:4];
        default:   spi_io_out[1]   = tx_sr[7];
      endcase
      if (tx_en_q) begin
        spi_io_oe = lane_mask(mode_q);
      end
    end
  end

  assign tx_ready = !hold_full;
  assign timeout  = cs_active && (tmo_cnt == '0);

endmodule

// File: tb/tb_spi_device_multi.sv
module tb_spi_device_multi;

  localparam int         HALF      = 6;   // clk cycles per spi_clk half period
  localparam logic [7:0] FILL_BYTE = 8'hFF;
  localparam int         W         = 25;  // {rx_cmd, rx_count[15:0], rx_data[7:0]}

  logic        clk;
  logic        reset;
  logic        spi_clk;
  logic        spi_cs_n;
  logic [3:0]  spi_io_in;
  logic [3:0]  spi_io_out;
  logic [3:0]  spi_io_oe;
  logic [1:0]  lane_mode;
  logic        tx_en;
  logic        rx_strobe;
  logic        rx_cmd;
  logic [7:0]  rx_data;
  logic [15:0] rx_count;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_underrun;
  logic        timeout;

  spi_device_multi #(
    .SYNC_STAGES (2),
    .TIMEOUT_BITS(4),
    .COUNT_BITS  (16),
    .FILL_BYTE   (8'hFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_clk    (spi_clk),
    .spi_cs_n   (spi_cs_n),
    .spi_io_in  (spi_io_in),
    .spi_io_out (spi_io_out),
    .spi_io_oe  (spi_io_oe),
    .lane_mode  (lane_mode),
    .tx_en      (tx_en),
    .rx_strobe  (rx_strobe),
    .rx_cmd     (rx_cmd),
    .rx_data    (rx_data),
    .rx_count   (rx_count),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_underrun(tx_underrun),
    .timeout    (timeout)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           ur_seen = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_underrun) ur_seen++;
      if (rx_strobe) begin
        if (exp_q.size() == 0) begin
          check("rx_strobe_unexpected", 32'(rx_strobe), 32'd0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e[7:0]));
          check("rx_count", 32'(rx_count), 32'(e[23:8]));
          check("rx_cmd", 32'(rx_cmd), 32'(e[24]));
        end
      end else if (rx_cmd) begin
        check("rx_cmd_without_strobe", 32'(rx_cmd), 32'd0);
      end
    end
  end

  // ---------------- reference helpers ----------------
  function automatic int lane_w(input logic [1:0] mode);
    if (mode == 2'd1) return 2;
    if (mode == 2'd2) return 4;
    return 1;
  endfunction

  function automatic logic [3:0] drive_mask(input logic [1:0] mode);
    if (mode == 2'd1) return 4'b0011;
    if (mode == 2'd2) return 4'b1111;
    return 4'b0010;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    spi_cs_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic push_tx(input logic [7:0] v);
    check("tx_ready_before_push", 32'(tx_ready), 32'd1);
    tx_data  = v;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom_range(0, 255));
    check("tx_ready_after_push", 32'(tx_ready), 32'd0);
  endtask

  // Master side of n_edges SPI clock cycles: put MOSI bits on the lanes,
  // sample MISO half a period later, then pulse spi_clk. Unused lanes carry
  // random noise the device must ignore.
  task automatic spi_edges(input logic [1:0] mode, input logic [7:0] mosi, input int n_edges,
                           input logic chk_oe, input logic [3:0] exp_oe,
                           output logic [7:0] miso);
    int         w;
    logic [3:0] wmask;
    logic [3:0] lanes;
    logic [3:0] sel;
    logic [7:0] acc;
    w     = lane_w(mode);
    wmask = 4'((1 << w) - 1);
    acc   = '0;
    for (int e = 0; e < n_edges; e++) begin
      lanes     = 4'((int'(mosi) >> (8 - w * (e + 1))) & int'(wmask));
      spi_io_in = (4'($urandom_range(0, 15)) & ~wmask) | lanes;
      wait_clk(HALF);
      if (w == 1) sel = {3'b000, spi_io_out[1]};
      else        sel = spi_io_out & wmask;
      acc = 8'((int'(acc) << w) | int'(sel));
      if (chk_oe) check("io_oe", 32'(spi_io_oe), 32'(exp_oe));
      spi_clk = 1'b1;
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
    miso = acc;
  endtask

  // One full transaction. push_m[b] means the host offers tx_a[b] at the
  // start of byte b; it is shifted out during byte b+1, otherwise the
  // boundary after byte b underruns.
  task automatic xact(input logic [1:0] mode, input logic ten, input int nbytes,
                      input logic [7:0] mosi_a[4], input logic [7:0] tx_a[4],
                      input logic [3:0] push_m);
    int         w;
    int         ur_exp;
    int         ur0;
    logic [3:0] exp_oe;
    logic [7:0] exp_miso;
    logic [7:0] miso;
    w         = lane_w(mode);
    exp_oe    = ten ? drive_mask(mode) : 4'b0000;
    exp_miso  = FILL_BYTE;
    ur_exp    = 0;
    ur0       = ur_seen;
    lane_mode = mode;
    tx_en     = ten;
    cs_low();
    for (int b = 0; b < nbytes; b++) begin
      check("tx_ready_idle", 32'(tx_ready), 32'd1);
      if (push_m[b]) push_tx(tx_a[b]);
      else ur_exp++;
      exp_q.push_back({(b == 0) ? 1'b1 : 1'b0, 16'(b + 1), mosi_a[b]});
      // Before the first rising edge the device has not latched tx_en/mode.
      spi_edges(mode, mosi_a[b], 8 / w, (b > 0) || !ten, exp_oe, miso);
      if (b > 0 || w == 1) check("miso_byte", 32'(miso), 32'(exp_miso));
      exp_miso = push_m[b] ? tx_a[b] : FILL_BYTE;
      wait_clk(4);
    end
    check("rx_count_final", 32'(rx_count), 32'(nbytes));
    cs_high();
    check("underrun_count", 32'(ur_seen - ur0), 32'(ur_exp));
    check("rx_drained", 32'(exp_q.size()), 32'd0);
    check("rx_count_deselected", 32'(rx_count), 32'd0);
    check("tx_ready_deselected", 32'(tx_ready), 32'd1);
    check("oe_deselected", 32'(spi_io_oe), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] mosi_a[4];
  logic [7:0] tx_a[4];
  logic [7:0] dummy;

  initial begin
    reset     = 1'b1;
    spi_clk   = 1'b0;
    spi_cs_n  = 1'b1;
    spi_io_in = 4'h0;
    lane_mode = 2'd0;
    tx_en     = 1'b0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mosi_a[i] = 8'h00;
      tx_a[i]   = 8'h00;
    end
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);

    check("reset_rx_strobe", 32'(rx_strobe), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_rx_count", 32'(rx_count), 32'd0);
    check("reset_tx_ready", 32'(tx_ready), 32'd1);
    check("reset_io_oe", 32'(spi_io_oe), 32'd0);
    check("reset_io_out", 32'(spi_io_out), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);

    // Single: command 9F then 00.
    mosi_a[0] = 8'h9F; mosi_a[1] = 8'h00;
    xact(2'd0, 1'b0, 2, mosi_a, tx_a, 4'b0000);

    // Quad receive EB with the device not driving.
    mosi_a[0] = 8'hEB;
    xact(2'd2, 1'b0, 1, mosi_a, tx_a, 4'b0000);

    // Dual transmit of a preloaded A5 in the second byte.
    mosi_a[0] = 8'h12; mosi_a[1] = 8'h34; tx_a[0] = 8'hA5;
    xact(2'd1, 1'b1, 2, mosi_a, tx_a, 4'b0001);

    // Single transmit with nothing supplied: fill bytes and underruns.
    mosi_a[0] = 8'h01; mosi_a[1] = 8'h02; mosi_a[2] = 8'h03;
    xact(2'd0, 1'b1, 3, mosi_a, tx_a, 4'b0000);

    // Deselect after 5 bits: nothing received, next byte is a command.
    lane_mode = 2'd0;
    tx_en     = 1'b0;
    cs_low();
    spi_edges(2'd0, 8'hA7, 5, 1'b0, 4'b0000, dummy);
    wait_clk(4);
    check("abort_rx_count", 32'(rx_count), 32'd0);
    cs_high();
    mosi_a[0] = 8'h3C;
    xact(2'd0, 1'b0, 1, mosi_a, tx_a, 4'b0000);

    // Reset after 5 bits with CS held low: same outcome.
    cs_low();
    spi_edges(2'd0, 8'h5A, 5, 1'b0, 4'b0000, dummy);
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(2);
    check("reset_mid_rx_count", 32'(rx_count), 32'd0);
    mosi_a[0] = 8'hC3;
    xact(2'd0, 1'b0, 1, mosi_a, tx_a, 4'b0000);

    // Idle-clock timeout: a rise does not clear it, a fall does.
    cs_low();
    check("timeout_fresh", 32'(timeout), 32'd0);
    wait_clk(20);
    check("timeout_idle", 32'(timeout), 32'd1);
    spi_clk = 1'b1;
    wait_clk(HALF);
    check("timeout_after_rise", 32'(timeout), 32'd1);
    spi_clk = 1'b0;
    wait_clk(3);
    check("timeout_after_fall", 32'(timeout), 32'd0);
    cs_high();
    check("timeout_deselected", 32'(timeout), 32'd0);

    // Randomized transactions over all lane modes.
    for (int t = 0; t < 14; t++) begin
      logic [1:0] m;
      logic       te;
      int         nb;
      logic [3:0] pm;
      m  = 2'($urandom_range(0, 3));
      te = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 4);
      pm = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        mosi_a[i] = 8'($urandom_range(0, 255));
        tx_a[i]   = 8'($urandom_range(0, 255));
      end
      xact(m, te, nb, mosi_a, tx_a, pm);
      wait_clk($urandom_range(1, 8));
    end

    wait_clk(10);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
